// File: rtl/cpu_oci_dct_packer.sv
// Producer side of the OCI compressed-trace path: packs 2-bit trace atoms LSB-first
// into a 15-atom word and offers it downstream on a valid/ready handshake. Trace is lossy.
module cpu_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int BUF_W  = ATOM_W * ATOMS,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    output logic              atom_ready,
    input  logic              flush,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [BUF_W-1:0] out_buf_q, out_buf_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_full_q, out_full_d;
    logic             flush_pend_q, flush_pend_d;
    logic             overflow_q, overflow_d;

    logic             drain, out_free, acc_full, accept, drop, xfer;
    logic [BUF_W-1:0] acc_ins;
    logic [CNT_W-1:0] cnt_ins;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        drain      = out_full_q & dct_ready;
        out_free   = !out_full_q | drain;
        acc_full   = (acc_cnt_q == CNT_FULL);
        atom_ready = !acc_full | out_free;
        accept     = atom_valid & atom_ready;
        drop       = atom_valid & !atom_ready;

        // Accumulator view including this cycle's atom; a held-full word takes no new atom.
        acc_ins = acc_q;
        cnt_ins = acc_cnt_q;
        if (accept && !acc_full) begin
            acc_ins[ATOM_W*int'(acc_cnt_q) +: ATOM_W] = atom_data;
            cnt_ins = acc_cnt_q + CNT_W'(1);
        end

        xfer = out_free & ((cnt_ins == CNT_FULL) |
                           ((flush | flush_pend_q) & (cnt_ins != '0)));

        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        out_buf_d    = out_buf_q;
        out_cnt_d    = out_cnt_q;
        out_full_d   = out_full_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = drop | (overflow_q & !overflow_clr);

        if (xfer) begin
            out_buf_d  = acc_ins;
            out_cnt_d  = cnt_ins;
            out_full_d = 1'b1;
            if (accept && acc_full) begin
                // Old full word leaves; the new atom opens the next word in slot 0.
                acc_d        = BUF_W'(atom_data);
                acc_cnt_d    = CNT_W'(1);
                flush_pend_d = flush;
            end else begin
                acc_d        = '0;
                acc_cnt_d    = '0;
                flush_pend_d = 1'b0;
            end
        end else begin
            if (drain) out_full_d = 1'b0;
            acc_d     = acc_ins;
            acc_cnt_d = cnt_ins;
            if (flush && cnt_ins != '0) flush_pend_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            out_buf_q    <= '0;
            out_cnt_q    <= '0;
            out_full_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            out_full_q   <= out_full_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dct_buffer = out_buf_q;
    assign dct_count  = out_cnt_q;
    assign dct_valid  = out_full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Self-checking bench for cpu_oci_dct_packer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        atom_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        overflow;
    logic        overflow_clr;

    cpu_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .atom_valid   (atom_valid),
        .atom_data    (atom_data),
        .atom_ready   (atom_ready),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .dct_valid    (dct_valid),
        .dct_ready    (dct_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [1:0] d, input logic f,
                         input logic r, input logic c);
        @(negedge clk);
        atom_valid   = v;
        atom_data    = d;
        flush        = f;
        dct_ready    = r;
        overflow_clr = c;
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        f;
        logic        r;
        logic        exp_valid;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [1:0] d, input logic f, input logic r,
                                input logic ev, input logic [29:0] eb, input logic [3:0] ec);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r;
        t.exp_valid = ev; t.exp_buf = eb; t.exp_cnt = ec;
        vecs.push_back(t);
    endfunction

    // Reference model: atoms held as plain lists, word packed by arithmetic.
    int m_acc[$];
    int m_out[$];
    bit m_out_v, m_ovf, m_fpend;

    function automatic logic [29:0] pack(input int q[$]);
        logic [31:0] w = 0;
        foreach (q[k]) w = w + (32'(q[k]) << (2 * k));
        return w[29:0];
    endfunction

    function automatic void model_step(input bit v, input int d, input bit f, input bit r, input bit c);
        bit free = !m_out_v || r;
        bit rdy  = (m_acc.size() < 15) || free;
        bit took = v && rdy;
        if (v && !rdy) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (m_out_v && r) m_out_v = 0;
        if (took && m_acc.size() == 15) begin
            m_out = m_acc; m_out_v = 1; m_acc = '{d}; m_fpend = f;
        end else begin
            if (took) m_acc.push_back(d);
            if (free && (m_acc.size() == 15 || ((f || m_fpend) && m_acc.size() > 0))) begin
                m_out = m_acc; m_out_v = 1; m_acc = {}; m_fpend = 0;
            end else if (f && m_acc.size() > 0) begin
                m_fpend = 1;
            end
        end
    endfunction

    initial begin
        reset = 1'b1;
        atom_valid = 0; atom_data = 0; flush = 0; dct_ready = 0; overflow_clr = 0;
        #12;
        check("rst_valid", 32'(dct_valid), 0);
        check("rst_buf", 32'(dct_buffer), 0);
        check("rst_cnt", 32'(dct_count), 0);
        check("rst_ready", 32'(atom_ready), 1);
        check("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: full 1,2,3,0 word, then a 3-atom flushed word and an empty flush.
        for (int i = 0; i < 15; i++) add(1, 2'((i + 1) % 4), 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 30'h3939_3939, 15);
        add(0, 0, 0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 30'h0000_001F, 3);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r, 0);
            check($sformatf("tbl%0d_valid", i), 32'(dct_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_ready", i), 32'(atom_ready), 1);
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_buf", i), 32'(dct_buffer), 32'(vecs[i].exp_buf));
                check($sformatf("tbl%0d_cnt", i), 32'(dct_count), 32'(vecs[i].exp_cnt));
            end
        end

        // Backpressure: two words of 2s, 31st atom dropped, overflow set/clear priority.
        for (int i = 0; i < 30; i++) begin
            drive(1, 2, 0, 0, 0);
            check("bp_ready", 32'(atom_ready), 1);
            if (i == 15) begin
                check("bp_valid", 32'(dct_valid), 1);
                check("bp_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
            end
        end
        drive(1, 2, 0, 0, 0);
        check("bp_full_ready", 32'(atom_ready), 0);
        check("bp_ovf_pre", 32'(overflow), 0);
        check("bp_hold_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
        check("bp_hold_cnt", 32'(dct_count), 15);
        drive(1, 2, 0, 0, 1);
        check("bp_ovf_set", 32'(overflow), 1);
        drive(0, 0, 0, 0, 1);
        check("ovf_set_wins", 32'(overflow), 1);
        drive(0, 0, 0, 0, 0);
        check("ovf_cleared", 32'(overflow), 0);
        check("bp_stable_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
        drive(0, 0, 0, 1, 0);
        check("bp_drain1_valid", 32'(dct_valid), 1);
        check("bp_drain1_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
        check("bp_drain1_ready", 32'(atom_ready), 1);
        drive(0, 0, 0, 1, 0);
        check("bp_drain2_valid", 32'(dct_valid), 1);
        check("bp_drain2_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
        check("bp_drain2_cnt", 32'(dct_count), 15);
        drive(0, 0, 0, 1, 0);
        check("bp_empty", 32'(dct_valid), 0);

        // Held-full accumulator released in the same cycle an atom arrives.
        for (int i = 0; i < 15; i++) drive(1, 3, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("sim_held_ready", 32'(atom_ready), 0);
        drive(1, 1, 0, 1, 0);
        check("sim_ready", 32'(atom_ready), 1);
        check("sim_old_buf", 32'(dct_buffer), 32'h3FFF_FFFF);
        drive(0, 0, 0, 1, 0);
        check("sim_held_valid", 32'(dct_valid), 1);
        check("sim_held_buf", 32'(dct_buffer), 32'h1555_5555);
        drive(0, 0, 1, 1, 0);
        check("sim_gap", 32'(dct_valid), 0);
        check("sim_no_ovf", 32'(overflow), 0);
        drive(0, 0, 0, 1, 0);
        check("sim_new_valid", 32'(dct_valid), 1);
        check("sim_new_buf", 32'(dct_buffer), 1);
        check("sim_new_cnt", 32'(dct_count), 1);

        // Reset mid-operation with overflow set and a partial word pending.
        for (int i = 0; i < 31; i++) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("mr_ovf_before", 32'(overflow), 1);
        for (int i = 0; i < 7; i++) drive(1, 1, 0, 1, 0);
        @(negedge clk);
        atom_valid = 0; flush = 0;
        reset = 1'b1;
        #1;
        check("mr_valid", 32'(dct_valid), 0);
        check("mr_cnt", 32'(dct_count), 0);
        check("mr_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 1, 0);
        check("mr_flush0", 32'(dct_valid), 0);
        drive(0, 0, 0, 1, 0);
        check("mr_flush1", 32'(dct_valid), 0);
        drive(0, 0, 0, 1, 0);
        check("mr_flush2", 32'(dct_valid), 0);

        // Randomized traffic against the reference model (starts from the empty state above).
        m_acc = {}; m_out = {}; m_out_v = 0; m_ovf = 0; m_fpend = 0;
        for (int n = 0; n < 3000; n++) begin
            bit v = ($urandom_range(0, 9) < 7);
            int d = $urandom_range(0, 3);
            bit f = ($urandom_range(0, 9) == 0);
            bit r = ($urandom_range(0, 9) < 4);
            bit c = ($urandom_range(0, 19) == 0);
            drive(v, 2'(d), f, r, c);
            check("rnd_valid", 32'(dct_valid), 32'(m_out_v));
            check("rnd_ready", 32'(atom_ready), 32'((m_acc.size() < 15) || !m_out_v || r));
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            if (m_out_v) begin
                check("rnd_buf", 32'(dct_buffer), 32'(pack(m_out)));
                check("rnd_cnt", 32'(dct_count), 32'(m_out.size()));
            end
            model_step(v, d, f, r, c);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
